// File: rtl/mux41_rr_sel.sv
// Round-robin select generator for a 4:1 mux.
// Produces a registered one-hot grant and the matching sel code, held stable for the whole grant.
module mux41_rr_sel #(
  parameter int HOLD_MIN  = 2,
  parameter int GRANT_MAX = 16,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic             done,
  output logic [1:0]       sel,
  output logic [3:0]       gnt,
  output logic             busy,
  output logic             timeout,
  output logic [CNT_W-1:0] sw_cnt
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MIN - 1);
  localparam logic [7:0] AGE_LAST  = 8'(GRANT_MAX - 1);

  state_t           state, state_nxt;
  logic [1:0]       last_ptr, last_ptr_nxt;
  logic [7:0]       age, age_nxt;
  logic             done_pend, done_pend_nxt;
  logic [1:0]       sel_nxt;
  logic [3:0]       gnt_nxt;
  logic             busy_nxt, timeout_nxt;
  logic [CNT_W-1:0] sw_cnt_nxt;

  logic [1:0]       pick_base;
  logic [2:0]       pick_res;
  logic             pick_vld;
  logic [1:0]       pick_idx;
  logic             hold_met, rel_done, rel_wd, rel_to, release_now;

  // Round-robin search from base+1 .. base+4; the lowest offset is evaluated last so it wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // During a grant the pointer that matters is the channel about to be released.
  assign pick_base   = (state == GRANT) ? sel : last_ptr;
  assign pick_res    = rr_pick(req, pick_base);
  assign pick_vld    = pick_res[2];
  assign pick_idx    = pick_res[1:0];

  assign hold_met    = (age >= HOLD_LAST);
  assign rel_done    = done | done_pend;
  assign rel_wd      = ~req[sel];
  assign rel_to      = (age == AGE_LAST);
  assign release_now = hold_met & (rel_done | rel_wd | rel_to);

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= 2'd0;
      gnt       <= 4'b0000;
      busy      <= 1'b0;
      timeout   <= 1'b0;
      sw_cnt    <= '0;
      last_ptr  <= 2'd3;
      age       <= 8'd0;
      done_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      sel       <= sel_nxt;
      gnt       <= gnt_nxt;
      busy      <= busy_nxt;
      timeout   <= timeout_nxt;
      sw_cnt    <= sw_cnt_nxt;
      last_ptr  <= last_ptr_nxt;
      age       <= age_nxt;
      done_pend <= done_pend_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    sel_nxt       = sel;
    gnt_nxt       = gnt;
    busy_nxt      = busy;
    timeout_nxt   = 1'b0;
    sw_cnt_nxt    = sw_cnt;
    last_ptr_nxt  = last_ptr;
    age_nxt       = age;
    done_pend_nxt = done_pend;

    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt  = GRANT;
          sel_nxt    = pick_idx;
          gnt_nxt    = 4'b0001 << pick_idx;
          busy_nxt   = 1'b1;
          age_nxt    = 8'd0;
          sw_cnt_nxt = sw_cnt + CNT_W'(1);
        end else begin
          done_pend_nxt = 1'b0;
        end
      end
      GRANT: begin
        if (release_now) begin
          // Timeout only flags a release that nothing else explains.
          timeout_nxt   = ~rel_done & ~rel_wd;
          last_ptr_nxt  = sel;
          done_pend_nxt = 1'b0;
          if (pick_vld) begin
            sel_nxt    = pick_idx;
            gnt_nxt    = 4'b0001 << pick_idx;
            age_nxt    = 8'd0;
            sw_cnt_nxt = sw_cnt + CNT_W'(1);
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = 4'b0000;
            busy_nxt  = 1'b0;
            age_nxt   = 8'd0;
          end
        end else begin
          age_nxt = (age == 8'hFF) ? age : age + 8'd1;
          if (done) begin
            done_pend_nxt = 1'b1;
          end else begin
            done_pend_nxt = done_pend;
          end
        end
      end
      default: begin
        state_nxt     = IDLE;
        gnt_nxt       = 4'b0000;
        busy_nxt      = 1'b0;
        done_pend_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mux41_rr_sel.sv
// Self-checking bench for mux41_rr_sel: directed table, corner sequences and a random run
// compared against a behavioural arbiter model.
module tb_mux41_rr_sel;
  localparam int HOLD_MIN  = 2;
  localparam int GRANT_MAX = 16;
  localparam int CNT_W     = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       busy, timeout;
  logic [7:0] sw_cnt;

  int checks = 0;
  int errors = 0;

  // model state: granted channel (-1 when idle), age in cycles, pending done, last served, etc.
  int m_ch, m_age, m_last, m_sel, m_cnt;
  bit m_pend, m_to;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;
    logic [7:0] cnt;
  } vec_t;
  vec_t tbl [15];

  always #5 clk = ~clk;

  mux41_rr_sel #(.HOLD_MIN(HOLD_MIN), .GRANT_MAX(GRANT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .sel(sel), .gnt(gnt), .busy(busy), .timeout(timeout), .sw_cnt(sw_cnt)
  );

  function automatic int pick(logic [3:0] r, int last);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (last + k) % 4;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic void m_reset();
    m_ch = -1; m_age = 0; m_last = 3; m_sel = 0; m_cnt = 0; m_pend = 0; m_to = 0;
  endfunction

  function automatic void m_grant(int c);
    m_ch = c; m_sel = c; m_age = 0; m_cnt = (m_cnt + 1) % 256;
  endfunction

  function automatic void m_step(logic [3:0] r, logic d);
    bit by_done, by_wd;
    int c;
    m_to = 0;
    if (m_ch < 0) begin
      c = pick(r, m_last);
      if (c >= 0) m_grant(c);
    end else begin
      by_done = d || m_pend;
      by_wd   = !r[m_ch];
      if (m_age >= HOLD_MIN - 1 && (by_done || by_wd || m_age == GRANT_MAX - 1)) begin
        m_to   = !by_done && !by_wd;
        m_last = m_ch;
        m_pend = 0;
        c = pick(r, m_last);
        if (c >= 0) m_grant(c);
        else m_ch = -1;
      end else begin
        if (d) m_pend = 1;
        if (m_age < 255) m_age++;
      end
    end
  endfunction

  function automatic logic [15:0] m_out();
    logic [3:0] g;
    g = 4'b0000;
    if (m_ch >= 0) g[m_ch] = 1'b1;
    return {g, 2'(m_sel), (m_ch >= 0), m_to, 8'(m_cnt)};
  endfunction

  function automatic logic [15:0] dut_out();
    return {gnt, sel, busy, timeout, sw_cnt};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got gnt/sel/busy/to/cnt=%h want %h", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic d);
    req = r; done = d;
    @(posedge clk);
    m_step(r, d);
    #1;
    check("model", dut_out(), m_out());
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'b0000; done = 1'b0;
    m_reset();
    @(posedge clk);
    #1;
    check("reset", dut_out(), 16'h0000);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; done = 1'b0;
    // fairness rows followed by a single request with an early done
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 8'd1};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 8'd1};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 8'd2};
    tbl[3]  = '{4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 8'd2};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 8'd3};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 8'd3};
    tbl[6]  = '{4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0, 8'd4};
    tbl[7]  = '{4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0, 8'd4};
    tbl[8]  = '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 8'd5};
    tbl[9]  = '{4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 8'd5};
    tbl[10] = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 8'd5};
    tbl[11] = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 8'd6};
    tbl[12] = '{4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 8'd6};
    tbl[13] = '{4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, 8'd6};
    tbl[14] = '{4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, 8'd6};

    #2;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].req, tbl[i].done);
      check($sformatf("table[%0d]", i), dut_out(),
            {tbl[i].gnt, tbl[i].sel, tbl[i].busy, tbl[i].timeout, tbl[i].cnt});
    end

    // asynchronous reset in the middle of a grant
    do_reset();
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    #2;
    rst = 1'b1;
    m_reset();
    #1;
    check("async_rst", dut_out(), 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(4'b1111, 1'b0);
    check("first_after_rst", dut_out(), {4'b0001, 2'd0, 1'b1, 1'b0, 8'd1});

    // forced release of a sole requester after GRANT_MAX cycles
    do_reset();
    step(4'b0010, 1'b0);
    for (int i = 0; i < GRANT_MAX - 1; i++) step(4'b0010, 1'b0);
    step(4'b0010, 1'b0);
    check("timeout_pulse", dut_out(), {4'b0010, 2'd1, 1'b1, 1'b1, 8'd2});
    step(4'b0010, 1'b0);
    check("timeout_clear", dut_out(), {4'b0010, 2'd1, 1'b1, 1'b0, 8'd2});

    // withdrawal hands over on the same edge; done beats timeout
    do_reset();
    step(4'b1001, 1'b0);
    step(4'b1001, 1'b0);
    step(4'b1001, 1'b0);
    step(4'b1000, 1'b0);
    check("withdraw_handover", dut_out(), {4'b1000, 2'd3, 1'b1, 1'b0, 8'd2});
    for (int i = 0; i < GRANT_MAX - 1; i++) step(4'b1000, 1'b0);
    step(4'b1000, 1'b1);
    check("done_over_timeout", dut_out(), {4'b1000, 2'd3, 1'b1, 1'b0, 8'd3});

    // grant counter wrap
    do_reset();
    for (int i = 0; i < 511; i++) step(4'b1111, 1'b1);
    check("cnt_wrap", dut_out(), {4'b1000, 2'd3, 1'b1, 1'b0, 8'd0});
    step(4'b1111, 1'b1);
    step(4'b1111, 1'b1);
    check("after_wrap", dut_out(), {4'b0001, 2'd0, 1'b1, 1'b0, 8'd1});

    // randomized traffic against the model
    do_reset();
    begin
      logic [3:0] r;
      r = 4'b0000;
      for (int i = 0; i < 2000; i++) begin
        if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
        step(r, ($urandom_range(0, 4) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
